// File: rtl/ads41_ddr_tx.sv
// ADS41 DDR LVDS transmit model: FIFO-fed or pattern-generated words split into
// rising (even bits) / falling (odd bits) half-words for per-pin ODDRs.
module ads41_ddr_tx #(
  parameter int          NBITS         = 12,
  parameter logic [15:0] FLIP_PN       = 16'h0000,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          TRAIN_LEN     = 64,
  parameter logic [15:0] TRAIN_PATTERN = 16'h0A5C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               train_start,
  input  logic [NBITS-1:0]   din,
  input  logic               din_ovr,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [NBITS/2-1:0] q_rise,
  output logic [NBITS/2-1:0] q_fall,
  output logic               ovr_out,
  output logic               busy,
  output logic               underflow,
  input  logic               underflow_clr
);

  localparam int HB = NBITS / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TRAIN_LEN + 1);
  localparam logic [NBITS-1:0] PAT  = TRAIN_PATTERN[NBITS-1:0];
  localparam logic [HB-1:0]    FLIP = FLIP_PN[HB-1:0];
  localparam logic [CW-1:0]    CNT_INIT = CW'(TRAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] w_q, w_d;
  logic             ovr_q, ovr_d;
  logic [NBITS-1:0] ramp_q, ramp_d;
  logic             tog_q, tog_d;
  logic             ph_q, ph_d;
  logic             uf_q, uf_d;

  logic [NBITS:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             empty, full, wr_en, pop;
  logic [NBITS:0]   head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_en = din_valid & ~full;
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign din_ready = ~full;
  assign ovr_out   = ovr_q;
  assign busy      = (state_q == TRAIN);
  assign underflow = uf_q;

  always_comb begin
    for (int i = 0; i < HB; i++) begin
      q_rise[i] = w_q[2*i]   ^ FLIP[i];
      q_fall[i] = w_q[2*i+1] ^ FLIP[i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= {din_ovr, din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      ovr_q   <= 1'b0;
      ramp_q  <= '0;
      tog_q   <= 1'b0;
      ph_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      ovr_q   <= ovr_d;
      ramp_q  <= ramp_d;
      tog_q   <= tog_d;
      ph_q    <= ph_d;
      uf_q    <= uf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    ovr_d   = ovr_q;
    ramp_d  = ramp_q;
    tog_d   = tog_q;
    ph_d    = ph_q;
    uf_d    = uf_q & ~underflow_clr;
    pop     = 1'b0;
    if (train_start) begin
      state_d = TRAIN;
      cnt_d   = CNT_INIT;
      ovr_d   = 1'b0;
      // a restart inside TRAIN keeps the alternation phase
      if (state_q == TRAIN) begin
        w_d  = ph_q ? ~PAT : PAT;
        ph_d = ~ph_q;
      end else begin
        w_d  = PAT;
        ph_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          w_d   = '0;
          ovr_d = 1'b0;
          if (enable) begin
            state_d = RUN;
            ramp_d  = '0;
            tog_d   = 1'b0;
          end
        end
        TRAIN: begin
          ovr_d = 1'b0;
          if (cnt_q == '0) begin
            w_d = '0;
            if (enable) begin
              state_d = RUN;
              ramp_d  = '0;
              tog_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            w_d   = ph_q ? ~PAT : PAT;
            ph_d  = ~ph_q;
          end
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
            w_d     = '0;
            ovr_d   = 1'b0;
          end else begin
            unique case (mode)
              2'd0: begin
                if (!empty) begin
                  pop   = 1'b1;
                  w_d   = head[NBITS-1:0];
                  ovr_d = head[NBITS];
                end else begin
                  uf_d = 1'b1;
                end
              end
              2'd1: begin
                w_d    = ramp_q;
                ovr_d  = 1'b0;
                ramp_d = ramp_q + 1'b1;
              end
              2'd2: begin
                w_d   = PAT;
                ovr_d = 1'b0;
              end
              default: begin
                w_d   = {NBITS{tog_q}};
                ovr_d = 1'b0;
                tog_d = ~tog_q;
              end
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads41_ddr_tx.sv
// Bench for ads41_ddr_tx: per-cycle expected words queued by stimulus,
// popped and compared by an independent monitor after each edge.
module tb_ads41_ddr_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic        train_start;
  logic [11:0] din;
  logic        din_ovr;
  logic        din_valid;
  logic        din_ready;
  logic [5:0]  q_rise;
  logic [5:0]  q_fall;
  logic        ovr_out;
  logic        busy;
  logic        underflow;
  logic        underflow_clr;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] FLIP = 16'h0003;

  ads41_ddr_tx #(
    .NBITS(12), .FLIP_PN(FLIP), .FIFO_DEPTH(4),
    .TRAIN_LEN(64), .TRAIN_PATTERN(16'h0A5C)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .train_start(train_start), .din(din), .din_ovr(din_ovr),
    .din_valid(din_valid), .din_ready(din_ready),
    .q_rise(q_rise), .q_fall(q_fall), .ovr_out(ovr_out),
    .busy(busy), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] w;
    logic        ovr;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [11:0] recover(input logic [5:0] r,
                                          input logic [5:0] f);
    logic [11:0] w;
    logic [15:0] fl;
    fl = FLIP;
    for (int i = 0; i < 6; i++) begin
      w[2*i]   = r[i] ^ fl[i];
      w[2*i+1] = f[i] ^ fl[i];
    end
    return w;
  endfunction

  // monitor
  initial begin
    exp_t e;
    logic [11:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = recover(q_rise, q_fall);
        n_tests++;
        if (got !== e.w || ovr_out !== e.ovr || busy !== e.busy) begin
          n_fail++;
          $display("FAIL word @%0t: got w=%h ovr=%b busy=%b, want w=%h ovr=%b busy=%b",
                   $time, got, ovr_out, busy, e.w, e.ovr, e.busy);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tx(input logic [11:0] w, input logic o, input logic b);
    exp_t e;
    e.w = w; e.ovr = o; e.busy = b;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] fill [4];
    fill[0] = 12'h0A1; fill[1] = 12'h0A2;
    fill[2] = 12'h0A3; fill[3] = 12'h0A4;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; train_start = 1'b0;
    din = '0; din_ovr = 1'b0; din_valid = 1'b0; underflow_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_q_rise", 32'(q_rise), 32'h03);
    chk("rst_q_fall", 32'(q_fall), 32'h03);
    chk("rst_ovr", 32'(ovr_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_uf", 32'(underflow), 32'h0);
    chk("rst_ready", 32'(din_ready), 32'h1);

    // 1: streaming from FIFO, 1-cycle latency, underflow afterwards
    rst = 1'b0; enable = 1'b1; din_valid = 1'b1; din = 12'h001;
    tx(12'h000, 1'b0, 1'b0);
    din = 12'h002;
    tx(12'h001, 1'b0, 1'b0);
    din = 12'h003; din_ovr = 1'b1;
    tx(12'h002, 1'b0, 1'b0);
    din = 12'h004; din_ovr = 1'b0;
    tx(12'h003, 1'b1, 1'b0);
    din_valid = 1'b0;
    tx(12'h004, 1'b0, 1'b0);
    tx(12'h004, 1'b0, 1'b0);
    chk("t1_uf", 32'(underflow), 32'h1);

    // 2: fill while idle, reject 5th, drain in order
    enable = 1'b0; underflow_clr = 1'b1;
    tx(12'h000, 1'b0, 1'b0);
    chk("t2_uf_clr", 32'(underflow), 32'h0);
    underflow_clr = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = fill[i];
      tx(12'h000, 1'b0, 1'b0);
    end
    chk("t2_full", 32'(din_ready), 32'h0);
    din = 12'h0BB;
    tx(12'h000, 1'b0, 1'b0);
    chk("t2_still_full", 32'(din_ready), 32'h0);
    din_valid = 1'b0; enable = 1'b1;
    tx(12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tx(fill[i], 1'b0, 1'b0);
    tx(12'h0A4, 1'b0, 1'b0);
    chk("t2_uf", 32'(underflow), 32'h1);
    chk("t2_ready", 32'(din_ready), 32'h1);

    // 3: training burst then ramp with wrap
    mode = 2'd1; train_start = 1'b1;
    tx(12'hA5C, 1'b0, 1'b1);
    train_start = 1'b0;
    for (int j = 1; j < 64; j++)
      tx((j % 2) ? 12'h5A3 : 12'hA5C, 1'b0, 1'b1);
    tx(12'h000, 1'b0, 1'b0);
    for (int i = 0; i <= 4096; i++) tx(12'(i), 1'b0, 1'b0);

    // 5: retrigger at cnt=10 extends training; 4: flipped constant
    mode = 2'd2; train_start = 1'b1;
    tx(12'hA5C, 1'b0, 1'b1);
    for (int j = 1; j < 118; j++) begin
      train_start = (j == 54);
      tx((j % 2) ? 12'h5A3 : 12'hA5C, 1'b0, 1'b1);
    end
    train_start = 1'b0;
    tx(12'h000, 1'b0, 1'b0);
    tx(12'hA5C, 1'b0, 1'b0);
    tx(12'hA5C, 1'b0, 1'b0);
    chk("t4_raw_rise", 32'(q_rise), 32'h0D);
    chk("t4_raw_fall", 32'(q_fall), 32'h31);

    mode = 2'd3;
    tx(12'h000, 1'b0, 1'b0);
    tx(12'hFFF, 1'b0, 1'b0);
    tx(12'h000, 1'b0, 1'b0);

    mode = 2'd2; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = fill[i];
      tx(12'hA5C, 1'b0, 1'b0);
    end
    din_valid = 1'b0;
    chk("t5_full", 32'(din_ready), 32'h0);
    chk("t5_uf_before", 32'(underflow), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_q_rise", 32'(q_rise), 32'h03);
    chk("arst_q_fall", 32'(q_fall), 32'h03);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_uf", 32'(underflow), 32'h0);
    chk("arst_ready", 32'(din_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_w", 32'(recover(q_rise, q_fall)), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
